// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined CPU: opcodes, ALU function
// selects, instruction field positions and datapath sizing.
package cpu_pkg;

    localparam int DW    = 8;
    localparam int NREGS = 4;
    localparam int AW    = 2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_CMP = 2'b10;

    // Instruction layout: [15:14] opcode, [13:12] rd, [11:10] rs1, [9:8] rs2, [7:0] imm
    localparam int OPC_LSB = 14;
    localparam int RD_LSB  = 12;
    localparam int RS1_LSB = 10;
    localparam int RS2_LSB = 8;
    localparam int IMM_LSB = 0;

    // One-hot mask selecting a single register, used by the pending-write scoreboard.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [AW-1:0] addr);
        return 4'b0001 << addr;
    endfunction

endpackage

// File: rtl/regfile_4x8.sv
// 4 x 8-bit register file: two combinational read ports, one clocked write port.
module regfile_4x8
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem_q [NREGS];
    logic [DW-1:0] mem_d [NREGS];

    // Next-state of the storage array: write port updates one entry.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d[waddr] = mem_q[waddr];
        end
    end

    // Storage registers, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: decodes 16-bit instructions, reads the
// register file with a writeback bypass, tracks in-flight writes with a
// pending-bit scoreboard and hands a registered payload to execute.
module id_stage
    import cpu_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [15:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_op1,
    output logic [DW-1:0] out_op2,
    output logic [1:0]    out_func_sel,
    output logic [1:0]    out_rd,
    output logic          out_wr_en,
    input  logic          wb_en,
    input  logic [1:0]    wb_addr,
    input  logic [DW-1:0] wb_data
);

    // Decoded fields
    logic [1:0]    opc_s, rd_s, rs1_s, rs2_s, func_s;
    logic [DW-1:0] imm_s;
    logic          uses_src_s, wr_en_dec_s;

    // Operand fetch / hazard
    logic [DW-1:0] rdata_a_s, rdata_b_s, op1_s, op2_s;
    logic          hit_rs1_s, hit_rs2_s, hit_rd_s;
    logic          raw_s, waw_s, in_ready_s, accept_s;

    // Scoreboard
    logic [NREGS-1:0] pend_q, pend_d, clr_mask_s, set_mask_s;

    // Output payload
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
    logic [1:0]    out_func_q, out_func_d, out_rd_q, out_rd_d;
    logic          out_wr_en_q, out_wr_en_d;

    regfile_4x8 u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs1_s),
        .raddr_b (rs2_s),
        .rdata_a (rdata_a_s),
        .rdata_b (rdata_b_s)
    );

    // Instruction decode: fields, ALU function, register usage.
    always_comb begin
        opc_s       = in_instr[OPC_LSB +: 2];
        rd_s        = in_instr[RD_LSB  +: 2];
        rs1_s       = in_instr[RS1_LSB +: 2];
        rs2_s       = in_instr[RS2_LSB +: 2];
        imm_s       = in_instr[IMM_LSB +: DW];
        uses_src_s  = (opc_s != OP_LDI);
        wr_en_dec_s = (opc_s != OP_CMP);
        case (opc_s)
            OP_ADD:  func_s = FN_ADD;
            OP_SUB:  func_s = FN_SUB;
            OP_CMP:  func_s = FN_CMP;
            OP_LDI:  func_s = FN_ADD;
            default: func_s = FN_ADD;
        endcase
    end

    // Operand selection with same-cycle writeback bypass, plus hazard detection.
    // A pending register that is being written back this cycle is not a hazard:
    // its value arrives through the bypass.
    always_comb begin
        hit_rs1_s = wb_en && (wb_addr == rs1_s);
        hit_rs2_s = wb_en && (wb_addr == rs2_s);
        hit_rd_s  = wb_en && (wb_addr == rd_s);

        if (!uses_src_s) begin
            op1_s = {DW{1'b0}};
            op2_s = imm_s;
        end else begin
            op1_s = hit_rs1_s ? wb_data : rdata_a_s;
            op2_s = hit_rs2_s ? wb_data : rdata_b_s;
        end

        raw_s = uses_src_s && ((pend_q[rs1_s] && !hit_rs1_s) ||
                               (pend_q[rs2_s] && !hit_rs2_s));
        waw_s = wr_en_dec_s && pend_q[rd_s] && !hit_rd_s;

        in_ready_s = (!out_valid_q || out_ready) && !(raw_s || waw_s);
        accept_s   = in_valid && in_ready_s;
    end

    // Scoreboard update: clear on writeback, set on accepted write; set applied last so it wins.
    always_comb begin
        clr_mask_s = wb_en ? reg_onehot(wb_addr) : {NREGS{1'b0}};
        set_mask_s = (accept_s && wr_en_dec_s) ? reg_onehot(rd_s) : {NREGS{1'b0}};
        pend_d     = (pend_q & ~clr_mask_s) | set_mask_s;
    end

    // Output payload next-state: load on accept, drop when consumed, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_func_d  = out_func_q;
        out_rd_d    = out_rd_q;
        out_wr_en_d = out_wr_en_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_op1_d   = op1_s;
            out_op2_d   = op2_s;
            out_func_d  = func_s;
            out_rd_d    = rd_s;
            out_wr_en_d = wr_en_dec_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= {NREGS{1'b0}};
            out_valid_q <= 1'b0;
            out_op1_q   <= {DW{1'b0}};
            out_op2_q   <= {DW{1'b0}};
            out_func_q  <= 2'b00;
            out_rd_q    <= 2'b00;
            out_wr_en_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            out_func_q  <= out_func_d;
            out_rd_q    <= out_rd_d;
            out_wr_en_q <= out_wr_en_d;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_q;
    assign out_op1      = out_op1_q;
    assign out_op2      = out_op2_q;
    assign out_func_sel = out_func_q;
    assign out_rd       = out_rd_q;
    assign out_wr_en    = out_wr_en_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected payloads are queued when an
// instruction is driven and compared when the stage presents its output.
module tb_id_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_op1, out_op2;
    logic [1:0]  out_func_sel, out_rd;
    logic        out_wr_en;
    logic        wb_en;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] func;
        logic [1:0] rd;
        logic       wr_en;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    int   n_checks = 0;
    int   n_errors = 0;

    id_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op1      (out_op1),
        .out_op2      (out_op2),
        .out_func_sel (out_func_sel),
        .out_rd       (out_rd),
        .out_wr_en    (out_wr_en),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk_instr(input logic [1:0] opc, input logic [1:0] rd,
                                             input logic [1:0] rs1, input logic [1:0] rs2,
                                             input logic [7:0] imm);
        return {opc, rd, rs1, rs2, imm};
    endfunction

    function automatic exp_t mk_exp(input logic [7:0] op1, input logic [7:0] op2,
                                    input logic [1:0] func, input logic [1:0] rd,
                                    input logic wr_en);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.func = func; e.rd = rd; e.wr_en = wr_en;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic wbe,
                         input logic [1:0] wba, input logic [7:0] wbd, input logic ordy);
        in_valid  = v;
        in_instr  = instr;
        wb_en     = wbe;
        wb_addr   = wba;
        wb_data   = wbd;
        out_ready = ordy;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_payload(input string tag, input exp_t e);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_op1"},   {24'd0, out_op1}, {24'd0, e.op1});
        chk({tag, "_op2"},   {24'd0, out_op2}, {24'd0, e.op2});
        chk({tag, "_func"},  {30'd0, out_func_sel}, {30'd0, e.func});
        chk({tag, "_rd"},    {30'd0, out_rd}, {30'd0, e.rd});
        chk({tag, "_wr_en"}, {31'd0, out_wr_en}, {31'd0, e.wr_en});
    endtask

    // Check in_ready, queue the expected payload if accepted, clock, then compare.
    task automatic issue(input string tag, input logic exp_rdy, input exp_t e);
        logic pushed;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, exp_rdy});
        pushed = exp_rdy && in_valid;
        if (pushed) sb_q.push_back(e);
        edge_step();
        if (pushed) begin
            chk({tag, "_sb_has_entry"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                held = sb_q.pop_front();
                cmp_payload(tag, held);
            end
        end
    endtask

    task automatic idle(input string tag, input logic wbe, input logic [1:0] wba,
                        input logic [7:0] wbd);
        drive(1'b0, 16'h0000, wbe, wba, wbd, 1'b1);
        edge_step();
        chk({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        exp_t none;
        none = mk_exp(8'h00, 8'h00, 2'b00, 2'd0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 2'd0, 8'h00, 1'b1);
        edge_step();
        edge_step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_op1",       {24'd0, out_op1}, 32'd0);
        chk("rst_op2",       {24'd0, out_op2}, 32'd0);
        chk("rst_func",      {30'd0, out_func_sel}, 32'd0);
        chk("rst_rd",        {30'd0, out_rd}, 32'd0);
        chk("rst_wr_en",     {31'd0, out_wr_en}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // LDI, then back-to-back accepts with writebacks (R1=05, R2=03)
        drive(1'b1, mk_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h05), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("ldi_r1", 1'b1, mk_exp(8'h00, 8'h05, FN_ADD, 2'd1, 1'b1));
        drive(1'b1, mk_instr(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h03), 1'b1, 2'd1, 8'h05, 1'b1);
        issue("ldi_r2", 1'b1, mk_exp(8'h00, 8'h03, FN_ADD, 2'd2, 1'b1));
        drive(1'b1, mk_instr(OP_SUB, 2'd3, 2'd1, 2'd2, 8'h00), 1'b1, 2'd2, 8'h03, 1'b1);
        issue("sub_r3", 1'b1, mk_exp(8'h05, 8'h03, FN_SUB, 2'd3, 1'b1));
        drive(1'b1, mk_instr(OP_CMP, 2'd0, 2'd1, 2'd2, 8'h00), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("cmp", 1'b1, mk_exp(8'h05, 8'h03, FN_CMP, 2'd0, 1'b0));
        // CMP must not have marked R0 pending
        drive(1'b1, mk_instr(OP_LDI, 2'd0, 2'd0, 2'd0, 8'hAA), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("ldi_r0_after_cmp", 1'b1, mk_exp(8'h00, 8'hAA, FN_ADD, 2'd0, 1'b1));
        idle("idle_wb_r3", 1'b1, 2'd3, 8'h08);
        idle("idle_wb_r0", 1'b1, 2'd0, 8'hAA);

        // RAW stall then bypassed accept
        drive(1'b1, mk_instr(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h11), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("ldi_r1b", 1'b1, mk_exp(8'h00, 8'h11, FN_ADD, 2'd1, 1'b1));
        drive(1'b1, mk_instr(OP_ADD, 2'd2, 2'd1, 2'd1, 8'h00), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("raw_stall1", 1'b0, none);
        chk("raw_stall_drain", {31'd0, out_valid}, 32'd0);
        issue("raw_stall2", 1'b0, none);
        drive(1'b1, mk_instr(OP_ADD, 2'd2, 2'd1, 2'd1, 8'h00), 1'b1, 2'd1, 8'h7F, 1'b1);
        issue("raw_bypass", 1'b1, mk_exp(8'h7F, 8'h7F, FN_ADD, 2'd2, 1'b1));

        // Backpressure: payload holds, nothing accepted
        drive(1'b1, mk_instr(OP_LDI, 2'd3, 2'd0, 2'd0, 8'h44), 1'b0, 2'd0, 8'h00, 1'b0);
        issue("bp_hold1", 1'b0, none);
        cmp_payload("bp_hold1", held);
        issue("bp_hold2", 1'b0, none);
        cmp_payload("bp_hold2", held);
        drive(1'b1, mk_instr(OP_LDI, 2'd3, 2'd0, 2'd0, 8'h44), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("bp_release", 1'b1, mk_exp(8'h00, 8'h44, FN_ADD, 2'd3, 1'b1));

        // Set wins over clear on R2, then WAW stall on R2
        drive(1'b1, mk_instr(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h55), 1'b1, 2'd2, 8'h99, 1'b1);
        issue("set_wins", 1'b1, mk_exp(8'h00, 8'h55, FN_ADD, 2'd2, 1'b1));
        drive(1'b1, mk_instr(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h66), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("waw_stall", 1'b0, none);

        // Asynchronous reset while a payload is held
        drive(1'b1, mk_instr(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h12), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("ldi_r0_pre_rst", 1'b1, mk_exp(8'h00, 8'h12, FN_ADD, 2'd0, 1'b1));
        drive(1'b0, mk_instr(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h77), 1'b0, 2'd0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_op1",       {24'd0, out_op1}, 32'd0);
        chk("arst_op2",       {24'd0, out_op2}, 32'd0);
        chk("arst_func",      {30'd0, out_func_sel}, 32'd0);
        chk("arst_rd",        {30'd0, out_rd}, 32'd0);
        chk("arst_wr_en",     {31'd0, out_wr_en}, 32'd0);
        chk("arst_in_ready",  {31'd0, in_ready}, 32'd1);
        edge_step();
        rst_n = 1'b1;

        // Pending bits dropped; writeback after reset lands in R3
        drive(1'b1, mk_instr(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h77), 1'b1, 2'd3, 8'h21, 1'b1);
        issue("post_rst_ldi_r2", 1'b1, mk_exp(8'h00, 8'h77, FN_ADD, 2'd2, 1'b1));
        drive(1'b1, mk_instr(OP_ADD, 2'd1, 2'd3, 2'd3, 8'h00), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("post_rst_add", 1'b1, mk_exp(8'h21, 8'h21, FN_ADD, 2'd1, 1'b1));
        drive(1'b1, mk_instr(OP_CMP, 2'd3, 2'd0, 2'd3, 8'h00), 1'b0, 2'd0, 8'h00, 1'b1);
        issue("post_rst_cmp_r0", 1'b1, mk_exp(8'h00, 8'h21, FN_CMP, 2'd3, 1'b0));
        idle("final", 1'b0, 2'd0, 8'h00);

        chk("sb_empty_at_end", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
